// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU output stage.
// Default widths, the occupancy state type and the count-width helper.
package alu_pkg;

    localparam int N_DEF     = 8;
    localparam int DEPTH_DEF = 4;
    localparam int ERRW_DEF  = 8;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PART,
        OCC_FULL
    } occ_state_t;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/alu_out_fifo_mem.sv
// Result storage for the ALU output stage.
// Registered write port, asynchronous read port, no reset on the array.
module alu_out_fifo_mem
    import alu_pkg::*;
#(
    parameter int W     = N_DEF + 1,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    // Write the incoming word at the write address.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_out_stage.sv
// Registered output stage behind the ALU: FWFT result FIFO with
// valid/ready on both sides, plus sticky error flag and error counter.
module alu_out_stage
    import alu_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int ERRW  = ERRW_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [N-1:0]            i_data,
    input  logic                    i_err,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [N-1:0]            o_data,
    output logic                    o_err,
    input  logic                    i_err_clr,
    output logic                    o_err_sticky,
    output logic [ERRW-1:0]         o_err_cnt,
    output logic [cnt_w(DEPTH)-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    occ_state_t      r_state;
    logic [ERRW-1:0] r_err_cnt;
    logic            r_err_sticky;

    logic            w_push;
    logic            w_pop;
    logic            w_err_push;
    logic [N:0]      w_rdata;

    // Handshake flags come straight from the registered occupancy state.
    assign o_ready    = (r_state != OCC_FULL);
    assign o_valid    = (r_state != OCC_EMPTY);
    assign w_push     = i_valid && o_ready;
    assign w_pop      = o_valid && i_ready;
    assign w_err_push = w_push && i_err;

    alu_out_fifo_mem #(
        .W     (N + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata ({i_err, i_data}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    // Head entry is forced to zero while empty so outputs read 0 after reset.
    assign o_data       = o_valid ? w_rdata[N-1:0] : '0;
    assign o_err        = o_valid & w_rdata[N];
    assign o_count      = r_count;
    assign o_err_cnt    = r_err_cnt;
    assign o_err_sticky = r_err_sticky;

    // Pointers, occupancy count and occupancy state move together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= OCC_EMPTY;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case (r_state)
                OCC_EMPTY: begin
                    if (w_push) begin
                        r_count <= C_ONE;
                        r_state <= OCC_PART;
                    end
                end
                OCC_PART: begin
                    if (w_push && !w_pop) begin
                        r_count <= r_count + C_ONE;
                        if (r_count == C_FULL - C_ONE) begin
                            r_state <= OCC_FULL;
                        end
                    end else if (w_pop && !w_push) begin
                        r_count <= r_count - C_ONE;
                        if (r_count == C_ONE) begin
                            r_state <= OCC_EMPTY;
                        end
                    end
                end
                OCC_FULL: begin
                    if (w_pop) begin
                        r_count <= C_FULL - C_ONE;
                        r_state <= OCC_PART;
                    end
                end
                default: begin
                    r_state <= OCC_EMPTY;
                end
            endcase
        end
    end

    // Error tracking: clear takes effect before a coincident errored push.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_cnt    <= '0;
            r_err_sticky <= 1'b0;
        end else if (i_err_clr) begin
            r_err_cnt    <= w_err_push ? ERRW'(1) : '0;
            r_err_sticky <= w_err_push;
        end else if (w_err_push) begin
            r_err_sticky <= 1'b1;
            if (r_err_cnt != {ERRW{1'b1}}) begin
                r_err_cnt <= r_err_cnt + ERRW'(1);
            end
        end
    end

endmodule
